// File: rtl/hazard_tnew_tracker_pkg.sv
// Shared Tuse/Tnew codes, forwarding encodings and the per-stage record
// used by the D/E/M/W hazard tracker.
package hazard_tnew_tracker_pkg;

  localparam int ADDR_W = 5;
  localparam int T_W    = 2;

  localparam logic [T_W-1:0] TUSE_NONE = 2'd3;
  localparam logic [T_W-1:0] T_LW      = 2'd2;
  localparam logic [T_W-1:0] T_ALU     = 2'd1;
  localparam logic [T_W-1:0] T_LINK    = 2'd0;

  // D-stage forwarding sources
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // E-stage forwarding sources
  localparam logic [1:0] EFWD_PIPE = 2'd0;
  localparam logic [1:0] EFWD_M    = 2'd1;
  localparam logic [1:0] EFWD_W    = 2'd2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] dst;
    logic [T_W-1:0]    tnew;
  } stage_t;

  function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Register $0 is hard-wired, so a write to it can never feed a reader.
  function automatic logic stage_match(input stage_t s, input logic [ADDR_W-1:0] a);
    return s.we && (s.dst == a) && (a != '0);
  endfunction

endpackage

// File: rtl/hazard_tnew_tracker_stage_reg.sv
// One shadow-pipe stage: {we, dst, tnew} with bubble load and optional
// saturating tnew decrement on the way in.
module hazard_stage_reg
  import hazard_tnew_tracker_pkg::*;
#(
  parameter bit DEC = 1'b1
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q.we   <= d.we;
      q.dst  <= d.dst;
      q.tnew <= DEC ? tnew_dec(d.tnew) : d.tnew;
    end
  end

endmodule

// File: rtl/hazard_tnew_tracker.sv
// Tracks in-flight destinations/Tnew through E/M/W and resolves D-stage
// stalls plus D- and E-stage forwarding selects.
module hazard_tnew_tracker
  import hazard_tnew_tracker_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] D_rs_addr,
  input  logic [ADDR_W-1:0] D_rt_addr,
  input  logic [T_W-1:0]    D_rs_Tuse,
  input  logic [T_W-1:0]    D_rt_Tuse,
  input  logic              D_reg_write_enable,
  input  logic [ADDR_W-1:0] D_dst_addr,
  input  logic [T_W-1:0]    D_Tnew,
  output logic              stall,
  output logic [1:0]        D_fwd_rs_sel,
  output logic [1:0]        D_fwd_rt_sel,
  output logic [1:0]        E_fwd_rs_sel,
  output logic [1:0]        E_fwd_rt_sel
);

  stage_t            stg [0:2];   // 0=E, 1=M, 2=W
  stage_t            d_stage;
  logic [ADDR_W-1:0] e_rs_reg;
  logic [ADDR_W-1:0] e_rt_reg;

  assign d_stage = {D_reg_write_enable, D_dst_addr, D_Tnew};

  // E captures D's Tnew as-is; each later stage ages it by one.
  hazard_stage_reg #(.DEC(1'b0)) u_stage_e (
    .clk    (clk),
    .reset_n(reset_n),
    .bubble (stall),
    .d      (d_stage),
    .q      (stg[0])
  );

  genvar gi;
  generate
    for (gi = 1; gi < 3; gi++) begin : g_stage
      hazard_stage_reg #(.DEC(1'b1)) u_stage (
        .clk    (clk),
        .reset_n(reset_n),
        .bubble (1'b0),
        .d      (stg[gi-1]),
        .q      (stg[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_rs_reg <= '0;
      e_rt_reg <= '0;
    end else if (stall) begin
      e_rs_reg <= '0;
      e_rt_reg <= '0;
    end else begin
      e_rs_reg <= D_rs_addr;
      e_rt_reg <= D_rt_addr;
    end
  end

  // W always carries tnew=0, so only E and M can hold a reader back.
  function automatic logic op_hazard(input stage_t e, input stage_t m,
                                     input logic [ADDR_W-1:0] a,
                                     input logic [T_W-1:0] tuse);
    if (tuse == TUSE_NONE)
      return 1'b0;
    return (stage_match(e, a) && (e.tnew > tuse)) ||
           (stage_match(m, a) && (m.tnew > tuse));
  endfunction

  // The youngest matching writer decides; if it is not ready, read RF (stall covers it).
  function automatic logic [1:0] d_select(input stage_t e, input stage_t m,
                                          input stage_t w,
                                          input logic [ADDR_W-1:0] a);
    if (stage_match(e, a)) return (e.tnew == '0) ? FWD_E : FWD_RF;
    if (stage_match(m, a)) return (m.tnew == '0) ? FWD_M : FWD_RF;
    if (stage_match(w, a)) return (w.tnew == '0) ? FWD_W : FWD_RF;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] e_select(input stage_t m, input stage_t w,
                                          input logic [ADDR_W-1:0] a);
    if (stage_match(m, a)) return (m.tnew == '0) ? EFWD_M : EFWD_PIPE;
    if (stage_match(w, a)) return (w.tnew == '0) ? EFWD_W : EFWD_PIPE;
    return EFWD_PIPE;
  endfunction

  assign stall = op_hazard(stg[0], stg[1], D_rs_addr, D_rs_Tuse) ||
                 op_hazard(stg[0], stg[1], D_rt_addr, D_rt_Tuse);

  assign D_fwd_rs_sel = d_select(stg[0], stg[1], stg[2], D_rs_addr);
  assign D_fwd_rt_sel = d_select(stg[0], stg[1], stg[2], D_rt_addr);
  assign E_fwd_rs_sel = e_select(stg[1], stg[2], e_rs_reg);
  assign E_fwd_rt_sel = e_select(stg[1], stg[2], e_rt_reg);

endmodule

// File: tb/tb_hazard_tnew_tracker.sv
// Directed bench for hazard_tnew_tracker: an age-based history model checked
// every negedge, plus hand-computed expectations for each scenario.
module tb_hazard_tnew_tracker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] D_rs_addr, D_rt_addr, D_dst_addr;
  logic [1:0] D_rs_Tuse, D_rt_Tuse, D_Tnew;
  logic       D_reg_write_enable;
  logic       stall;
  logic [1:0] D_fwd_rs_sel, D_fwd_rt_sel, E_fwd_rs_sel, E_fwd_rt_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_tnew_tracker dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .D_rs_addr         (D_rs_addr),
    .D_rt_addr         (D_rt_addr),
    .D_rs_Tuse         (D_rs_Tuse),
    .D_rt_Tuse         (D_rt_Tuse),
    .D_reg_write_enable(D_reg_write_enable),
    .D_dst_addr        (D_dst_addr),
    .D_Tnew            (D_Tnew),
    .stall             (stall),
    .D_fwd_rs_sel      (D_fwd_rs_sel),
    .D_fwd_rt_sel      (D_fwd_rt_sel),
    .E_fwd_rs_sel      (E_fwd_rs_sel),
    .E_fwd_rt_sel      (E_fwd_rt_sel)
  );

  // hist[k] = instruction that entered E k cycles ago (k=0 E, 1 M, 2 W).
  typedef struct {
    bit we;
    int dst;
    int tnew;
    int rs;
    int rt;
  } ent_t;

  ent_t hist [3];

  function automatic int remaining(input int k);
    return (hist[k].tnew > k) ? hist[k].tnew - k : 0;
  endfunction

  function automatic bit mmatch(input int k, input int a);
    return hist[k].we && (hist[k].dst == a) && (a != 0);
  endfunction

  function automatic bit op_stall(input int a, input int tuse);
    if (tuse == 3) return 1'b0;
    for (int k = 0; k < 2; k++)
      if (mmatch(k, a) && remaining(k) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_stall();
    return op_stall(int'(D_rs_addr), int'(D_rs_Tuse)) ||
           op_stall(int'(D_rt_addr), int'(D_rt_Tuse));
  endfunction

  function automatic int model_dsel(input int a);
    for (int k = 0; k < 3; k++)
      if (mmatch(k, a)) return (remaining(k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  function automatic int model_esel(input int a);
    for (int k = 1; k < 3; k++)
      if (mmatch(k, a)) return (remaining(k) == 0) ? k : 0;
    return 0;
  endfunction

  function automatic ent_t next_entry();
    ent_t n;
    n = '{0, 0, 0, 0, 0};
    if (!model_stall()) begin
      n.we   = D_reg_write_enable;
      n.dst  = int'(D_dst_addr);
      n.tnew = int'(D_Tnew);
      n.rs   = int'(D_rs_addr);
      n.rt   = int'(D_rt_addr);
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) hist[k] <= '{0, 0, 0, 0, 0};
    end else begin
      hist[0] <= next_entry();
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_stall", int'(stall), int'(model_stall()));
    check("m_d_rs", int'(D_fwd_rs_sel), model_dsel(int'(D_rs_addr)));
    check("m_d_rt", int'(D_fwd_rt_sel), model_dsel(int'(D_rt_addr)));
    check("m_e_rs", int'(E_fwd_rs_sel), model_esel(hist[0].rs));
    check("m_e_rt", int'(E_fwd_rt_sel), model_esel(hist[0].rt));
  end

  task automatic set_d(input int we, input int dst, input int tnew,
                       input int rs, input int rs_tuse, input int rt, input int rt_tuse);
    D_reg_write_enable = we[0];
    D_dst_addr         = dst[4:0];
    D_Tnew             = tnew[1:0];
    D_rs_addr          = rs[4:0];
    D_rs_Tuse          = rs_tuse[1:0];
    D_rt_addr          = rt[4:0];
    D_rt_Tuse          = rt_tuse[1:0];
    $display("D: we=%0d dst=%0d tnew=%0d rs=%0d/%0d rt=%0d/%0d t=%0t",
             we, dst, tnew, rs, rs_tuse, rt, rt_tuse, $time);
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 3, 0, 3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    nop();
    #3;
    check("rst_stall", int'(stall), 0);
    check("rst_d_rs", int'(D_fwd_rs_sel), 0);
    check("rst_e_rs", int'(E_fwd_rs_sel), 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    // lw $1 then add reading $1 at Tuse=1
    set_d(1, 1, 2, 0, 3, 0, 3); #1 check("t1_lw_nostall", int'(stall), 0);
    tick(); set_d(1, 4, 1, 1, 1, 0, 3); #1 check("t1_stall", int'(stall), 1);
    tick(); #1;
    check("t1_stall_clear", int'(stall), 0);
    check("t1_d_rs", int'(D_fwd_rs_sel), 0);
    check("t1_e_rs_bubble", int'(E_fwd_rs_sel), 0);
    tick(); nop(); #1 check("t1_e_rs_w", int'(E_fwd_rs_sel), 2);
    tick(); tick();

    // lw $2 then beq reading $2 at Tuse=0
    set_d(1, 2, 2, 0, 3, 0, 3);
    tick(); set_d(0, 0, 0, 2, 0, 0, 3); #1 check("t2_stall1", int'(stall), 1);
    tick(); #1 check("t2_stall2", int'(stall), 1);
    tick(); #1;
    check("t2_stall_clear", int'(stall), 0);
    check("t2_d_rs_w", int'(D_fwd_rs_sel), 3);
    tick(); nop(); tick(); tick();

    // ori $3 -> jr $3 ; jal -> jr $31
    set_d(1, 3, 1, 0, 3, 0, 3);
    tick(); set_d(0, 0, 0, 3, 0, 0, 3); #1 check("t3_stall", int'(stall), 1);
    tick(); #1;
    check("t3_stall_clear", int'(stall), 0);
    check("t3_d_rs_m", int'(D_fwd_rs_sel), 2);
    tick(); set_d(1, 31, 0, 0, 3, 0, 3);
    tick(); set_d(0, 0, 0, 31, 0, 0, 3); #1;
    check("t3_jal_nostall", int'(stall), 0);
    check("t3_d_rs_e", int'(D_fwd_rs_sel), 1);
    tick(); nop(); tick(); tick();

    // writes to $0 never match
    set_d(1, 0, 2, 0, 3, 0, 3);
    tick(); set_d(0, 0, 0, 0, 0, 0, 0); #1;
    check("t4_r0_stall", int'(stall), 0);
    check("t4_r0_d_rs", int'(D_fwd_rs_sel), 0);
    check("t4_r0_d_rt", int'(D_fwd_rt_sel), 0);
    tick(); nop(); tick(); tick(); tick();

    // two writers of $5; reader with rs==rt
    set_d(1, 5, 1, 0, 3, 0, 3);
    tick(); set_d(1, 5, 1, 0, 3, 0, 3);
    tick(); set_d(0, 0, 0, 5, 0, 5, 3); #1;
    check("t4_dup_stall", int'(stall), 1);
    check("t4_dup_d_rs", int'(D_fwd_rs_sel), 0);
    check("t4_dup_d_rt", int'(D_fwd_rt_sel), 0);
    tick(); #1;
    check("t4_dup_clear", int'(stall), 0);
    check("t4_dup_d_rs_m", int'(D_fwd_rs_sel), 2);
    check("t4_dup_d_rt_m", int'(D_fwd_rt_sel), 2);
    tick(); nop(); tick(); tick();

    // reset pulse during a stall
    set_d(1, 6, 2, 0, 3, 0, 3);
    tick(); set_d(0, 0, 0, 6, 0, 0, 3); #1 check("t5_stall", int'(stall), 1);
    #2 reset_n = 1'b0;
    #2;
    check("t5_rst_stall", int'(stall), 0);
    check("t5_rst_d_rs", int'(D_fwd_rs_sel), 0);
    check("t5_rst_e_rs", int'(E_fwd_rs_sel), 0);
    nop();
    #8 reset_n = 1'b1;
    tick(); tick();
    set_d(0, 0, 0, 6, 0, 6, 0); #1;
    check("t5_post_stall", int'(stall), 0);
    check("t5_post_d_rs", int'(D_fwd_rs_sel), 0);
    check("t5_post_d_rt", int'(D_fwd_rt_sel), 0);
    tick(); nop(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
